// File: rtl/multi_tick_gen_if.sv
// multi_tick_gen_if: control and output bundle for multi_tick_gen.
//   en         per-channel run enable
//   pause      global freeze (counters and toggles hold)
//   restart    one-cycle strobe, realigns every channel
//   cfg_we     period write strobe
//   cfg_ch     channel index for the write
//   cfg_period new period, in clk cycles
//   tick       one-cycle pulse per period, per channel
//   tog        toggles on every tick, per channel
// master: the side driving controls (game logic / bench)
// slave : the tick generator itself
interface multi_tick_gen_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 29,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic [N_CH-1:0]  en;
  logic             pause;
  logic             restart;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  tog;

  modport master (
    output en, pause, restart, cfg_we, cfg_ch, cfg_period,
    input  tick, tog
  );

  modport slave (
    input  en, pause, restart, cfg_we, cfg_ch, cfg_period,
    output tick, tog
  );
endinterface

// File: rtl/multi_tick_gen.sv
// multi_tick_gen: N_CH independent programmable periodic tick generators.
// Each channel counts clk cycles up to its period P and emits a registered
// one-cycle tick every P cycles, plus a toggle output with period 2P.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset; periods return to DEF_PERIOD
//   bus    multi_tick_gen_if.slave (enables, pause, restart, period
//          write port, tick/tog outputs)
module multi_tick_gen #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 29,
  parameter int DEF_PERIOD = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  multi_tick_gen_if.slave   bus
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_PERIOD);

  logic [CNT_W-1:0] r_period [N_CH];
  logic [CNT_W-1:0] r_cnt    [N_CH];
  logic [N_CH-1:0]  r_tick;
  logic [N_CH-1:0]  r_tog;
  logic [N_CH-1:0]  w_wr_hit;

  // Out-of-range channel indices match no channel, so such writes vanish.
  always_comb begin
    w_wr_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.cfg_we && (int'(bus.cfg_ch) == i)) w_wr_hit[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        r_period[i] <= DEF_VAL;
        r_cnt[i]    <= '0;
      end
      r_tick <= '0;
      r_tog  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        // Period update is independent of restart so both can land together.
        if (w_wr_hit[i]) r_period[i] <= bus.cfg_period;

        if (bus.restart) begin
          r_cnt[i]  <= '0;
          r_tick[i] <= 1'b0;
          r_tog[i]  <= 1'b0;
        end else if (w_wr_hit[i]) begin
          r_cnt[i]  <= '0;
          r_tick[i] <= 1'b0;
        end else if (!bus.en[i] || (r_period[i] == '0)) begin
          r_cnt[i]  <= '0;
          r_tick[i] <= 1'b0;
        end else if (bus.pause) begin
          r_tick[i] <= 1'b0;
        end else if (r_cnt[i] == r_period[i] - ONE) begin
          // Any period write clears cnt, so cnt never passes P-1.
          r_cnt[i]  <= '0;
          r_tick[i] <= 1'b1;
          r_tog[i]  <= ~r_tog[i];
        end else begin
          r_cnt[i]  <= r_cnt[i] + ONE;
          r_tick[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.tick = r_tick;
  assign bus.tog  = r_tog;

endmodule
